// File: rtl/amber48_pkg.sv
// Shared amber48 pipeline types and widths: execute-stage payload, trap causes.
package amber48_pkg;

    localparam int unsigned XLEN           = 48;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned DMEM_DEPTH     = 256;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        TRAP_NONE       = 3'd0,
        TRAP_ILLEGAL    = 3'd1,
        TRAP_BREAKPOINT = 3'd2,
        TRAP_DATA_FAULT = 3'd3,
        TRAP_ECALL      = 3'd4
    } amber48_trap_e;

    typedef struct packed {
        logic                      valid;
        logic                      trap;
        amber48_trap_e             trap_cause;
        logic                      load;
        logic                      store;
        logic                      writeback_en;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]           result;
        logic [XLEN-1:0]           store_data;
    } amber48_execute_out_s;

endpackage

// File: rtl/amber48_mem_wb.sv
// amber48 memory/writeback stage: data-memory access, register writeback, trap/retire report.
// Optional feature: define AMBER48_MEM_BOUNDS_CHECK_EN to fault out-of-range accesses.
module amber48_mem_wb
    import amber48_pkg::*;
#(
    parameter int unsigned DMEM_DEPTH_P   = DMEM_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  amber48_execute_out_s      ex_i,
    output logic                      ex_ready_o,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [7:0]                dmem_addr_o,
    output logic [XLEN-1:0]           dmem_wdata_o,
    input  logic                      dmem_ready_i,
    input  logic                      dmem_rvalid_i,
    input  logic [XLEN-1:0]           dmem_rdata_i,
    input  logic                      dmem_err_i,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [XLEN-1:0]           rf_wdata_o,
    output logic                      retire_o,
    output logic                      trap_o,
    output amber48_trap_e             trap_cause_o
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned BAU_W  = XLEN - 3;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      capture;
    logic                      rf_we_d, retire_d, trap_d;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_d;
    logic [XLEN-1:0]           rf_wdata_d;
    amber48_trap_e             trap_cause_d;

    logic [BAU_W-1:0]  bau;
    logic [ADDR_W-1:0] addr_c;
    logic              is_mem, misaligned;

    assign bau        = ex_i.result[XLEN-1:3];
    assign addr_c     = ADDR_W'(bau % BAU_W'(DMEM_DEPTH_P));
    assign is_mem     = ex_i.load || ex_i.store;
    assign misaligned = (ex_i.result[2:0] != 3'b000);

`ifdef AMBER48_MEM_BOUNDS_CHECK_EN
    logic out_of_bounds;
    assign out_of_bounds = (bau >= BAU_W'(DMEM_DEPTH_P));
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus next values of the registered result outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;
        rf_we_d      = 1'b0;
        rf_waddr_d   = '0;
        rf_wdata_d   = '0;
        retire_d     = 1'b0;
        trap_d       = 1'b0;
        trap_cause_d = TRAP_NONE;

        unique case (state_q)
            IDLE: begin
                if (ex_i.valid) begin
                    if (ex_i.trap) begin
                        trap_d       = 1'b1;
                        trap_cause_d = ex_i.trap_cause;
                    end else if (is_mem && misaligned) begin
                        trap_d       = 1'b1;
                        trap_cause_d = TRAP_DATA_FAULT;
`ifdef AMBER48_MEM_BOUNDS_CHECK_EN
                    end else if (is_mem && out_of_bounds) begin
                        trap_d       = 1'b1;
                        trap_cause_d = TRAP_DATA_FAULT;
`endif
                    end else if (is_mem) begin
                        capture = 1'b1;
                        state_d = REQ;
                    end else begin
                        retire_d = 1'b1;
                        if (ex_i.writeback_en && (ex_i.rd != REG_ZERO)) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = ex_i.rd;
                            rf_wdata_d = ex_i.result;
                        end
                    end
                end
            end
            REQ: begin
                if (dmem_ready_i) begin
                    if (dmem_we_o) begin
                        state_d  = IDLE;
                        retire_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response arriving on the timeout cycle still completes the load.
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                    if (dmem_err_i) begin
                        trap_d       = 1'b1;
                        trap_cause_d = TRAP_DATA_FAULT;
                    end else begin
                        retire_d = 1'b1;
                        if (rd_q != REG_ZERO) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = rd_q;
                            rf_wdata_d = dmem_rdata_i;
                        end
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = IDLE;
                    trap_d       = 1'b1;
                    trap_cause_d = TRAP_DATA_FAULT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            rd_q         <= '0;
            ex_ready_o   <= 1'b1;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= '0;
            rf_wdata_o   <= '0;
            retire_o     <= 1'b0;
            trap_o       <= 1'b0;
            trap_cause_o <= TRAP_NONE;
        end else begin
            cnt_q      <= cnt_d;
            ex_ready_o <= (state_d == IDLE);
            dmem_req_o <= (state_d == REQ);
            if (capture) begin
                rd_q         <= ex_i.rd;
                dmem_we_o    <= ex_i.store;
                dmem_addr_o  <= addr_c;
                dmem_wdata_o <= ex_i.store_data;
            end
            rf_we_o      <= rf_we_d;
            rf_waddr_o   <= rf_waddr_d;
            rf_wdata_o   <= rf_wdata_d;
            retire_o     <= retire_d;
            trap_o       <= trap_d;
            trap_cause_o <= trap_cause_d;
        end
    end

endmodule
